// File: rtl/qpi_flash_responder_pkg.sv
// qpi_flash_responder_pkg: opcodes, FSM states and read-parameter tables shared by the QPI flash responder.
package qpi_flash_responder_pkg;
  localparam logic [7:0] OP_RSTEN     = 8'h66;
  localparam logic [7:0] OP_RST       = 8'h99;
  localparam logic [7:0] OP_QPI_EN    = 8'h38;
  localparam logic [7:0] OP_QPI_EX    = 8'hFF;
  localparam logic [7:0] OP_PARAM     = 8'hC0;
  localparam logic [7:0] OP_READ      = 8'h0B;
  localparam logic [7:0] OP_READ_WRAP = 8'h0C;
  typedef enum logic [2:0] {
    SPI_CMD, QPI_CMD, QPI_ADDR, QPI_PARAM, QPI_DUMMY, QPI_DATA, IGNORE, RSTWAIT
  } state_t;
  localparam logic [3:0]  DUMMY_CLKS [4] = '{4'd2, 4'd4, 4'd6, 4'd8};
  localparam logic [23:0] WRAP_MASK  [4] = '{24'h7, 24'hF, 24'h1F, 24'h3F};
  function automatic logic [23:0] next_addr(input logic [23:0] a, input logic wrap, input logic [1:0] ws);
    return wrap ? (a & ~WRAP_MASK[ws]) | ((a + 24'd1) & WRAP_MASK[ws]) : a + 24'd1;
  endfunction
endpackage

// File: rtl/qpi_rd_addr_gen.sv
// qpi_rd_addr_gen: holds the read address, advances it linearly or inside the wrap window, and pulses MEM_RE.
module qpi_rd_addr_gen
  import qpi_flash_responder_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        ld,
  input  logic        inc,
  input  logic        wrap,
  input  logic [1:0]  ws,
  input  logic [23:0] ld_addr,
  output logic        mem_re,
  output logic [23:0] mem_addr
);
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      mem_re   <= 1'b0;
      mem_addr <= '0;
    end else begin
      mem_re   <= ld | inc;
      mem_addr <= ld ? ld_addr : inc ? next_addr(mem_addr, wrap, ws) : mem_addr;
    end
  end
endmodule

// File: rtl/qpi_flash_responder.sv
// qpi_flash_responder: SPI/QPI flash read responder with soft reset and prefetching fast read.
// Define QPI_WRAP_EN to enable the 0Ch wrapped fast read.
module qpi_flash_responder
  import qpi_flash_responder_pkg::*;
#(
  parameter int         RST_CYCLES = 1800,
  parameter logic [7:0] DEF_PARAM  = 8'h00
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        XPICS,
  input  logic        XPICLK_EN,
  input  logic [3:0]  XPIi,
  output logic [3:0]  XPIo,
  output logic [3:0]  XPIoe,
  output logic        MEM_RE,
  output logic [23:0] MEM_ADDR,
  input  logic [7:0]  MEM_RDATA,
  output logic        BUSY
);
  localparam int RW = $clog2(RST_CYCLES + 1);
  state_t state, state_d, cmd_state;
  logic qpi, qpi_nxt, arm, rd_pend, wrap_rd, ld, inc, fclk, cmd_done, rd_op;
  logic [1:0] dum_sel, wrap_sel;
  logic [6:0] sr;
  logic [7:0] cmd_c, cur_byte, nxt_byte, fetched;
  logic [19:0] addr_sr;
  logic [2:0] cnt;
  logic [RW-1:0] rcnt;
  assign fclk     = !XPICS && XPICLK_EN;
  assign cmd_c    = qpi ? {sr[3:0], XPIi} : {sr, XPIi[0]};
  assign cmd_done = fclk && (state == SPI_CMD || state == QPI_CMD) && cnt == (qpi ? 3'd1 : 3'd7);
  assign fetched  = rd_pend ? MEM_RDATA : nxt_byte;
`ifdef QPI_WRAP_EN
  assign rd_op = cmd_c == OP_READ || cmd_c == OP_READ_WRAP;
  always_ff @(posedge HCLK)
    if (HRESET) wrap_rd <= 1'b0;
    else if (cmd_done) wrap_rd <= cmd_c == OP_READ_WRAP;
`else
  assign rd_op   = cmd_c == OP_READ;
  assign wrap_rd = 1'b0;
`endif
  assign cmd_state = (cmd_c == OP_RST && arm) ? RSTWAIT :
                     (qpi && cmd_c == OP_PARAM) ? QPI_PARAM :
                     (qpi && rd_op) ? QPI_ADDR : IGNORE;
  always_ff @(posedge HCLK)
    if (HRESET) state <= SPI_CMD;
    else state <= state_d;
  always_comb begin
    state_d = state;
    ld      = 1'b0;
    inc     = 1'b0;
    if (state == RSTWAIT) state_d = (rcnt == RW'(RST_CYCLES - 1)) ? SPI_CMD : RSTWAIT;
    else if (XPICS) state_d = qpi_nxt ? QPI_CMD : SPI_CMD;
    else if (fclk)
      case (state)
        SPI_CMD, QPI_CMD: state_d = cmd_done ? cmd_state : state;
        QPI_PARAM: state_d = cnt == 3'd1 ? IGNORE : state;
        QPI_ADDR: begin
          ld      = cnt == 3'd5;
          state_d = ld ? QPI_DUMMY : state;
        end
        QPI_DUMMY: begin
          inc     = {1'b0, cnt} == DUMMY_CLKS[dum_sel] - 4'd1;
          state_d = inc ? QPI_DATA : state;
        end
        QPI_DATA: inc = cnt[0];
        default: ;
      endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      {qpi, qpi_nxt, arm, rd_pend} <= '0;
      {dum_sel, wrap_sel} <= {DEF_PARAM[5:4], DEF_PARAM[1:0]};
      sr       <= '0;
      addr_sr  <= '0;
      cnt      <= '0;
      rcnt     <= '0;
      cur_byte <= '0;
      nxt_byte <= '0;
    end else begin
      cnt      <= (XPICS || state_d != state) ? 3'd0 : cnt + {2'b0, fclk};
      rcnt     <= state == RSTWAIT ? rcnt + 1'b1 : '0;
      sr       <= fclk ? cmd_c[6:0] : sr;
      addr_sr  <= fclk ? {addr_sr[15:0], XPIi} : addr_sr;
      rd_pend  <= MEM_RE;
      nxt_byte <= fetched;
      cur_byte <= inc ? fetched : cur_byte;
      if (cmd_done) arm <= cmd_c == OP_RSTEN;
      // Mode change is staged and only committed when the frame closes
      if (cmd_done && cmd_c == (qpi ? OP_QPI_EX : OP_QPI_EN)) qpi_nxt <= !qpi;
      if (XPICS && state != RSTWAIT) qpi <= qpi_nxt;
      if (state == QPI_PARAM && fclk && cnt == 3'd1) {dum_sel, wrap_sel} <= {cmd_c[5:4], cmd_c[1:0]};
      if (state == RSTWAIT && state_d == SPI_CMD) begin
        {qpi, qpi_nxt, arm} <= '0;
        {dum_sel, wrap_sel} <= {DEF_PARAM[5:4], DEF_PARAM[1:0]};
      end
    end
  end
  qpi_rd_addr_gen u_addr_gen (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .ld      (ld),
    .inc     (inc),
    .wrap    (wrap_rd),
    .ws      (wrap_sel),
    .ld_addr ({addr_sr, XPIi}),
    .mem_re  (MEM_RE),
    .mem_addr(MEM_ADDR)
  );
  assign BUSY  = state == RSTWAIT;
  assign XPIoe = state == QPI_DATA ? 4'hF : 4'h0;
  assign XPIo  = state != QPI_DATA ? 4'h0 : cnt[0] ? cur_byte[3:0] : cur_byte[7:4];
endmodule

// File: tb/tb_qpi_flash_responder.sv
// tb_qpi_flash_responder: table-driven and randomized reads against a byte-level flash model.
module tb_qpi_flash_responder;
  logic HCLK = 1'b0, HRESET = 1'b1, XPICS = 1'b1, XPICLK_EN = 1'b0;
  logic [3:0] XPIi = 4'h0, XPIo, XPIoe;
  logic MEM_RE, BUSY;
  logic [23:0] MEM_ADDR;
  logic [7:0] MEM_RDATA = 8'h00, prm = 8'h00;
  int total = 0, bad = 0, re_n = 0;
  logic [23:0] re_q[$];
  typedef struct { logic [7:0] prm; logic [23:0] addr; int nb; int dum; } vec_t;
  vec_t tv[4];

  qpi_flash_responder dut (
    .HCLK(HCLK), .HRESET(HRESET), .XPICS(XPICS), .XPICLK_EN(XPICLK_EN), .XPIi(XPIi),
    .XPIo(XPIo), .XPIoe(XPIoe), .MEM_RE(MEM_RE), .MEM_ADDR(MEM_ADDR),
    .MEM_RDATA(MEM_RDATA), .BUSY(BUSY)
  );

  always #5 HCLK = ~HCLK;

  function automatic logic [7:0] memf(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'hA5;
  endfunction

  function automatic logic [23:0] nxa(input logic [23:0] a, input bit w, input logic [23:0] wsz);
    return w ? a - (a % wsz) + ((a % wsz) + 24'd1) % wsz : a + 24'd1;
  endfunction

  function automatic int expd(input logic [7:0] p);
    return 2 * (int'(p[5:4]) + 1);
  endfunction

  // Flash array: returns the byte one clock after each read strobe, garbage otherwise
  always @(posedge HCLK) begin
    MEM_RDATA <= MEM_RE === 1'b1 ? memf(MEM_ADDR) : 8'($urandom);
    if (MEM_RE === 1'b1) begin
      re_q.push_back(MEM_ADDR);
      re_n++;
    end
  end

  task automatic tick(input logic cs, input logic en, input logic [3:0] d);
    XPICS = cs; XPICLK_EN = en; XPIi = d;
    @(posedge HCLK); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cs_hi();
    tick(1'b1, 1'b0, 4'($urandom));
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(1'b0, 1'b1, {3'($urandom), b[i]});
  endtask

  task automatic qpi_cmd(input logic [7:0] b);
    tick(1'b0, 1'b1, b[7:4]);
    tick(1'b0, 1'b1, b[3:0]);
  endtask

  task automatic set_param(input logic [7:0] p);
    qpi_cmd(8'hC0);
    qpi_cmd(p);
    cs_hi();
    prm = p;
  endtask

  task automatic ign(input string nm, input bit q, input logic [7:0] op);
    int r0 = re_n;
    logic ok = 1'b1;
    if (q) qpi_cmd(op); else spi_cmd(op);
    repeat (20) begin
      tick(1'b0, 1'b1, 4'($urandom));
      if (XPIoe !== 4'h0 || XPIo !== 4'h0) ok = 1'b0;
    end
    chk({nm, "_oe"}, 32'(ok), 32'd1);
    chk({nm, "_re"}, re_n - r0, 0);
    cs_hi();
  endtask

  task automatic wait_busy(input string nm);
    int n = 0;
    while (BUSY === 1'b1 && n < 3000) begin
      n++;
      tick(1'($urandom), 1'($urandom), 4'($urandom));
    end
    chk(nm, n, 1800);
    cs_hi();
  endtask

  task automatic rd(input logic [7:0] op, input logic [23:0] a, input int nb, input int exp_d,
                    input bit w, input bit stall);
    int k = 0;
    logic [23:0] cur = a;
    logic [7:0] m;
    logic [3:0] e;
    logic [23:0] ea[$];
    re_q.delete();
    qpi_cmd(op);
    for (int i = 5; i >= 0; i--) tick(1'b0, 1'b1, a[i*4+:4]);
    while (XPIoe == 4'h0 && k < 12) begin
      tick(1'b0, 1'b1, 4'($urandom));
      k++;
    end
    chk("dummy", k, exp_d);
    for (int b = 0; b < nb; b++) begin
      ea.push_back(cur);
      m = memf(cur);
      for (int h = 0; h < 2; h++) begin
        e = h ? m[3:0] : m[7:4];
        if (stall) repeat ($urandom_range(0, 2)) tick(1'b0, 1'b0, 4'($urandom));
        chk("data_oe", XPIoe, 4'hF);
        chk("nibble", XPIo, e);
        tick(1'b0, 1'b1, 4'($urandom));
      end
      cur = nxa(cur, w, 24'(8 << prm[1:0]));
    end
    cs_hi();
    chk("oe_idle", XPIoe, 4'h0);
    chk("re_count", 32'(re_q.size() >= nb), 32'd1);
    for (int i = 0; i < nb && i < re_q.size(); i++) chk("re_addr", re_q[i], ea[i]);
  endtask

  initial begin
    int r0;
    logic [7:0] p;
    tv[0] = '{8'h30, 24'h000010, 3, 8};
    tv[1] = '{8'h00, 24'hFFFFFF, 4, 2};
    tv[2] = '{8'h10, 24'h123456, 2, 4};
    tv[3] = '{8'h23, 24'hABCDEF, 2, 6};
    repeat (3) tick(1'b1, 1'b0, 4'h0);
    chk("rst_xpio", XPIo, 4'h0);
    chk("rst_xpioe", XPIoe, 4'h0);
    chk("rst_mem_re", MEM_RE, 1'b0);
    chk("rst_mem_addr", MEM_ADDR, 24'h0);
    chk("rst_busy", BUSY, 1'b0);
    HRESET = 1'b0;
    cs_hi();
    // 66h then an unrelated command clears the arm, so 99h is not a reset
    spi_cmd(8'h66); cs_hi();
    spi_cmd(8'h9F); cs_hi();
    spi_cmd(8'h99); cs_hi();
    chk("arm_cleared", BUSY, 1'b0);
    spi_cmd(8'h66); cs_hi();
    spi_cmd(8'h99);
    chk("busy_on", BUSY, 1'b1);
    wait_busy("busy_len1");
    spi_cmd(8'h38); cs_hi();
    for (int i = 0; i < 4; i++) begin
      set_param(tv[i].prm);
      rd(8'h0B, tv[i].addr, tv[i].nb, tv[i].dum, 1'b0, 1'b0);
    end
    r0 = re_n;
    qpi_cmd(8'h0B);
    repeat (3) tick(1'b0, 1'b1, 4'($urandom));
    cs_hi();
    chk("abort_oe", XPIoe, 4'h0);
    chk("abort_re", re_n - r0, 0);
    rd(8'h0B, 24'h00ABCD, 2, expd(prm), 1'b0, 1'b1);
    ign("qpi_38", 1'b1, 8'h38);
    ign("qpi_9f", 1'b1, 8'h9F);
    repeat (6) begin
      p = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      set_param(p);
      rd(8'h0B, 24'($urandom), $urandom_range(1, 3), expd(p), 1'b0, 1'b1);
    end
`ifdef QPI_WRAP_EN
    set_param(8'h02);
    rd(8'h0C, 24'h00001C, 8, 2, 1'b1, 1'b1);
`else
    ign("qpi_0c", 1'b1, 8'h0C);
`endif
    set_param(8'h30);
    qpi_cmd(8'h0B);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 4'h5);
    repeat (8) tick(1'b0, 1'b1, 4'h0);
    chk("mid_oe", XPIoe, 4'hF);
    HRESET = 1'b1;
    tick(1'b1, 1'b0, 4'h0);
    HRESET = 1'b0;
    chk("hrst_oe", XPIoe, 4'h0);
    chk("hrst_xpio", XPIo, 4'h0);
    chk("hrst_re", MEM_RE, 1'b0);
    chk("hrst_addr", MEM_ADDR, 24'h0);
    prm = 8'h00;
    spi_cmd(8'h38); cs_hi();
    rd(8'h0B, 24'($urandom), 2, 2, 1'b0, 1'b1);
    qpi_cmd(8'hFF); cs_hi();
    ign("spi_9f", 1'b0, 8'h9F);
    spi_cmd(8'h66); cs_hi();
    spi_cmd(8'h99);
    chk("busy_on2", BUSY, 1'b1);
    wait_busy("busy_len2");
    ign("spi_0b", 1'b0, 8'h0B);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
